ym_bus_master: RTL and testbench

//  Bus initiator for the YM2149/AY PSG register interface. Accepts queued register

---
 rtl/ym_bus_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_ym_bus_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym_bus_master.sv
// YM2149/AY PSG bus initiator: queues register requests and sequences BDIR/BC/DI cycles,
// skipping the address phase when the target register is already latched in the PSG.
module ym_bus_master #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WR,
  input  logic [3:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RD_VALID,
  output logic [7:0] RD_DATA,
  output logic       BUSY,
  output logic       PSG_CS,
  output logic       PSG_BDIR,
  output logic       PSG_BC,
  output logic [7:0] PSG_DI,
  input  logic [7:0] PSG_DO
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned MAX_CYC = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned PH_W    = $clog2(MAX_CYC + 1);

  localparam logic [PH_W-1:0]  SETUP_LD  = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]  STROBE_LD = PH_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_RECOV,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_RECOV,
    ST_R_SAMPLE
  } state_t;

  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] nxt_count;
  logic             push;
  logic             pop;
  logic             empty;
  req_t             head;
  req_t             cur;

  state_t           state;
  state_t           nxt_state;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  nxt_phase;
  logic [7:0]       nxt_di;
  logic             nxt_cs;
  logic             nxt_bdir;
  logic             nxt_bc;
  logic             rd_cap;

  logic             cache_vld;
  logic [3:0]       cache_addr;

  assign head  = fifo_mem[rd_ptr];
  assign empty = (count == '0);
  assign push  = REQ_VALID && REQ_READY;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    nxt_count = count;
    if (push && !pop) begin
      nxt_count = count + CNT_W'(1);
    end else if (!push && pop) begin
      nxt_count = count - CNT_W'(1);
    end
  end

  // FIFO storage write port
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{wr: REQ_WR, addr: REQ_ADDR, data: REQ_DATA};
    end
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      REQ_READY <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= nxt_count;
      REQ_READY <= (nxt_count != DEPTH_C);
    end
  end

  // Next-state, phase counter and next bus pin values
  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    pop       = 1'b0;
    nxt_di    = PSG_DI;
    rd_cap    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          nxt_phase = SETUP_LD;
          if (cache_vld && (cache_addr == head.addr)) begin
            if (head.wr) begin
              nxt_state = ST_D_SETUP;
              nxt_di    = head.data;
            end else begin
              nxt_state = ST_R_SAMPLE;
            end
          end else begin
            nxt_state = ST_A_SETUP;
            nxt_di    = {4'h0, head.addr};
          end
        end
      end
      ST_A_SETUP: begin
        if (phase == '0) begin
          nxt_state = ST_A_STROBE;
          nxt_phase = STROBE_LD;
        end else begin
          nxt_phase = phase - PH_W'(1);
        end
      end
      ST_A_STROBE: begin
        if (phase == '0) begin
          nxt_state = ST_A_RECOV;
        end else begin
          nxt_phase = phase - PH_W'(1);
        end
      end
      ST_A_RECOV: begin
        nxt_phase = SETUP_LD;
        if (cur.wr) begin
          nxt_state = ST_D_SETUP;
          nxt_di    = cur.data;
        end else begin
          nxt_state = ST_R_SAMPLE;
        end
      end
      ST_D_SETUP: begin
        if (phase == '0) begin
          nxt_state = ST_D_STROBE;
          nxt_phase = STROBE_LD;
        end else begin
          nxt_phase = phase - PH_W'(1);
        end
      end
      ST_D_STROBE: begin
        if (phase == '0) begin
          nxt_state = ST_D_RECOV;
        end else begin
          nxt_phase = phase - PH_W'(1);
        end
      end
      ST_D_RECOV: begin
        nxt_state = ST_IDLE;
      end
      ST_R_SAMPLE: begin
        if (phase == '0) begin
          nxt_state = ST_IDLE;
          rd_cap    = 1'b1;
        end else begin
          nxt_phase = phase - PH_W'(1);
        end
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase

    nxt_cs   = (nxt_state != ST_IDLE);
    nxt_bdir = (nxt_state == ST_A_STROBE) || (nxt_state == ST_D_STROBE);
    nxt_bc   = (nxt_state == ST_A_SETUP) || (nxt_state == ST_A_STROBE) ||
               (nxt_state == ST_A_RECOV);
  end

  // State and phase counter registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      phase <= '0;
    end else begin
      state <= nxt_state;
      phase <= nxt_phase;
    end
  end

  // Working request and latched-address cache
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cur        <= '0;
      cache_vld  <= 1'b0;
      cache_addr <= '0;
    end else begin
      if (pop) cur <= head;
      if (state == ST_A_RECOV) begin
        cache_vld  <= 1'b1;
        cache_addr <= cur.addr;
      end
    end
  end

  // Registered bus pins, read-back and status
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PSG_CS   <= 1'b0;
      PSG_BDIR <= 1'b0;
      PSG_BC   <= 1'b0;
      PSG_DI   <= '0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
      BUSY     <= 1'b0;
    end else begin
      PSG_CS   <= nxt_cs;
      PSG_BDIR <= nxt_bdir;
      PSG_BC   <= nxt_bc;
      PSG_DI   <= nxt_di;
      RD_VALID <= rd_cap;
      if (rd_cap) RD_DATA <= PSG_DO;
      BUSY     <= (nxt_state != ST_IDLE) || (nxt_count != '0);
    end
  end

endmodule

// File: tb/tb_ym_bus_master.sv
// Directed bench for ym_bus_master: default-timing instance plus a SETUP=3/STROBE=1 instance,
// each attached to a small PSG register model.
module tb_ym_bus_master;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic [1:0]      req_valid;
  logic [1:0]      req_wr;
  logic [1:0][3:0] req_addr;
  logic [1:0][7:0] req_data;
  logic [1:0]      rdy_v;
  logic [1:0]      rdv_v;
  logic [1:0][7:0] rdd_v;
  logic [1:0]      busy_v;
  logic [1:0]      cs_v;
  logic [1:0]      bdir_v;
  logic [1:0]      bc_v;
  logic [1:0][7:0] di_v;
  logic [1:0][7:0] do_v;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ym_bus_master u_dut0 (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(req_valid[0]), .REQ_READY(rdy_v[0]), .REQ_WR(req_wr[0]),
    .REQ_ADDR(req_addr[0]), .REQ_DATA(req_data[0]),
    .RD_VALID(rdv_v[0]), .RD_DATA(rdd_v[0]), .BUSY(busy_v[0]),
    .PSG_CS(cs_v[0]), .PSG_BDIR(bdir_v[0]), .PSG_BC(bc_v[0]),
    .PSG_DI(di_v[0]), .PSG_DO(do_v[0])
  );

  ym_bus_master #(.FIFO_DEPTH(16), .SETUP_CYC(3), .STROBE_CYC(1)) u_dut1 (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(req_valid[1]), .REQ_READY(rdy_v[1]), .REQ_WR(req_wr[1]),
    .REQ_ADDR(req_addr[1]), .REQ_DATA(req_data[1]),
    .RD_VALID(rdv_v[1]), .RD_DATA(rdd_v[1]), .BUSY(busy_v[1]),
    .PSG_CS(cs_v[1]), .PSG_BDIR(bdir_v[1]), .PSG_BC(bc_v[1]),
    .PSG_DI(di_v[1]), .PSG_DO(do_v[1])
  );

  // PSG register file model: BDIR&BC latches address, BDIR&!BC writes data
  logic [7:0] psg_reg [2][16];
  logic [3:0] latch   [2];

  always @(negedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < 2; k++) begin
        latch[k] <= '0;
        for (int i = 0; i < 16; i++) psg_reg[k][i] <= 8'h17 + 8'(i);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (bdir_v[k]) begin
          if (bc_v[k]) latch[k] <= di_v[k][3:0];
          else         psg_reg[k][latch[k]] <= di_v[k];
        end
      end
    end
  end

  assign do_v[0] = psg_reg[0][latch[0]];
  assign do_v[1] = psg_reg[1][latch[1]];

  // Bus monitor: strobe counts, data log, strobe width, setup and hold stability
  int         setup_exp [2] = '{1, 3};
  int         strobe_exp[2] = '{2, 1};
  int         astb[2]     = '{0, 0};
  int         dstb[2]     = '{0, 0};
  int         rvcnt[2]    = '{0, 0};
  int         badsetup[2] = '{0, 0};
  int         badlen[2]   = '{0, 0};
  int         badstab[2]  = '{0, 0};
  int         stab[2]     = '{0, 0};
  int         hilen[2]    = '{0, 0};
  logic [1:0] prev_bdir   = '0;
  logic [1:0] prev_cs     = '0;
  logic [8:0] prev_bcdi[2];
  logic [8:0] rise_bcdi[2];
  logic [7:0] last_adi[2];
  logic [7:0] dlog[2][64];

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (rdv_v[k]) rvcnt[k] <= rvcnt[k] + 1;
      if (bdir_v[k] && !prev_bdir[k]) begin
        if (bc_v[k]) begin
          astb[k]     <= astb[k] + 1;
          last_adi[k] <= di_v[k];
        end else begin
          dstb[k]                <= dstb[k] + 1;
          dlog[k][dstb[k] % 64]  <= di_v[k];
        end
        if (stab[k] != setup_exp[k]) badsetup[k] <= badsetup[k] + 1;
        hilen[k]     <= 1;
        rise_bcdi[k] <= {bc_v[k], di_v[k]};
      end else if (bdir_v[k]) begin
        hilen[k] <= hilen[k] + 1;
        if ({bc_v[k], di_v[k]} != rise_bcdi[k]) badstab[k] <= badstab[k] + 1;
      end else if (prev_bdir[k]) begin
        if (hilen[k] != strobe_exp[k]) badlen[k] <= badlen[k] + 1;
      end
      if (!bdir_v[k] && cs_v[k]) begin
        stab[k] <= (prev_cs[k] && !prev_bdir[k] && ({bc_v[k], di_v[k]} == prev_bcdi[k]))
                   ? stab[k] + 1 : 1;
      end else begin
        stab[k] <= 0;
      end
      prev_bdir[k] <= bdir_v[k];
      prev_cs[k]   <= cs_v[k];
      prev_bcdi[k] <= {bc_v[k], di_v[k]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input int k, input logic w, input logic [3:0] a, input logic [7:0] d);
    int n;
    n = 0;
    while (!rdy_v[k] && n < 500) begin
      @(negedge CLK);
      n++;
    end
    chk("push_ready_timeout", 32'(rdy_v[k]), 32'd1);
    req_wr[k]    = w;
    req_addr[k]  = a;
    req_data[k]  = d;
    req_valid[k] = 1'b1;
    @(negedge CLK);
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy_v[k] && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_idle_timeout", 32'(busy_v[k]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int s_a, s_d, s_rv, s_bl, s_bs, s_st;
    int i, guard, refusals, first_ref;
    logic acc;

    req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0;
    RESET_N = 1'b0;
    step(3);
    chk("rst_bdir",  32'(bdir_v[0]), 32'd0);
    chk("rst_bc",    32'(bc_v[0]),   32'd0);
    chk("rst_cs",    32'(cs_v[0]),   32'd0);
    chk("rst_di",    32'(di_v[0]),   32'd0);
    chk("rst_rdv",   32'(rdv_v[0]),  32'd0);
    chk("rst_rdd",   32'(rdd_v[0]),  32'd0);
    chk("rst_busy",  32'(busy_v[0]), 32'd0);
    chk("rst_ready", 32'(rdy_v[0]),  32'd1);
    RESET_N = 1'b1;
    step(1);

    // Write R7=0xF8 with address phase
    s_a = astb[0]; s_d = dstb[0]; s_rv = rvcnt[0];
    s_bl = badlen[0]; s_bs = badsetup[0]; s_st = badstab[0];
    push(0, 1'b1, 4'd7, 8'hF8);
    chk("t1_busy_start", 32'(busy_v[0]), 32'd1);
    step(8);
    chk("t1_busy_c8", 32'(busy_v[0]), 32'd1);
    step(1);
    chk("t1_busy_c9", 32'(busy_v[0]), 32'd0);
    chk("t1_addr_strobes", 32'(astb[0] - s_a), 32'd1);
    chk("t1_data_strobes", 32'(dstb[0] - s_d), 32'd1);
    chk("t1_addr_di", 32'(last_adi[0]), 32'h07);
    chk("t1_data_di", 32'(dlog[0][s_d % 64]), 32'hF8);
    chk("t1_psg_r7", 32'(psg_reg[0][7]), 32'hF8);
    chk("t1_no_rdvalid", 32'(rvcnt[0] - s_rv), 32'd0);
    chk("t1_strobe_len", 32'(badlen[0] - s_bl), 32'd0);
    chk("t1_setup", 32'(badsetup[0] - s_bs), 32'd0);
    chk("t1_stable", 32'(badstab[0] - s_st), 32'd0);

    // Back-to-back writes to R0: second skips the address phase
    s_a = astb[0]; s_d = dstb[0];
    push(0, 1'b1, 4'd0, 8'h10);
    push(0, 1'b1, 4'd0, 8'h20);
    wait_idle(0);
    chk("t2_addr_strobes", 32'(astb[0] - s_a), 32'd1);
    chk("t2_data_strobes", 32'(dstb[0] - s_d), 32'd2);
    chk("t2_order0", 32'(dlog[0][s_d % 64]), 32'h10);
    chk("t2_order1", 32'(dlog[0][(s_d + 1) % 64]), 32'h20);
    chk("t2_psg_r0", 32'(psg_reg[0][0]), 32'h20);

    // Read R8 (model holds 0x1F), RD_VALID 5 cycles after pop
    s_rv = rvcnt[0];
    push(0, 1'b0, 4'd8, 8'h00);
    step(5);
    chk("t3_rdv_early", 32'(rdv_v[0]), 32'd0);
    step(1);
    chk("t3_rdv_pulse", 32'(rdv_v[0]), 32'd1);
    chk("t3_rdd", 32'(rdd_v[0]), 32'h1F);
    step(1);
    chk("t3_rdv_end", 32'(rdv_v[0]), 32'd0);
    wait_idle(0);
    step(3);
    chk("t3_rdd_held", 32'(rdd_v[0]), 32'h1F);
    chk("t3_rdv_count", 32'(rvcnt[0] - s_rv), 32'd1);

    // Write then read the same register
    s_a = astb[0];
    push(0, 1'b1, 4'd3, 8'hA5);
    push(0, 1'b0, 4'd3, 8'h00);
    wait_idle(0);
    chk("t3_wr_rd_data", 32'(rdd_v[0]), 32'hA5);
    push(0, 1'b0, 4'd3, 8'h00);
    step(1);
    chk("t3_cached_rdv_early", 32'(rdv_v[0]), 32'd0);
    step(1);
    chk("t3_cached_rdv", 32'(rdv_v[0]), 32'd1);
    chk("t3_cached_rdd", 32'(rdd_v[0]), 32'hA5);
    chk("t3_addr_strobes", 32'(astb[0] - s_a), 32'd1);
    wait_idle(0);

    // Fill the FIFO: one push offered per cycle, 19 writes
    s_a = astb[0]; s_d = dstb[0];
    i = 0; guard = 0; refusals = 0; first_ref = -1;
    while (i < 19 && guard < 400) begin
      req_wr[0]    = 1'b1;
      req_addr[0]  = 4'(i);
      req_data[0]  = 8'h40 + 8'(i);
      req_valid[0] = 1'b1;
      acc = rdy_v[0];
      if (!acc) begin
        refusals++;
        if (first_ref < 0) first_ref = i;
      end
      @(negedge CLK);
      guard++;
      if (acc) i++;
    end
    req_valid[0] = 1'b0;
    chk("t4_all_pushed", 32'(i), 32'd19);
    chk("t4_first_refusal", 32'(first_ref), 32'd18);
    chk("t4_refusals", 32'(refusals), 32'd2);
    wait_idle(0);
    for (int j = 0; j < 19; j++) begin
      chk("t4_order", 32'(dlog[0][(s_d + j) % 64]), 32'h40 + 32'(j));
    end
    chk("t4_addr_strobes", 32'(astb[0] - s_a), 32'd19);
    chk("t4_psg_r0", 32'(psg_reg[0][0]), 32'h50);
    chk("t4_psg_r2", 32'(psg_reg[0][2]), 32'h52);
    chk("t4_psg_r5", 32'(psg_reg[0][5]), 32'h45);
    chk("t4_psg_r15", 32'(psg_reg[0][15]), 32'h4F);
    chk("t4_ready_after", 32'(rdy_v[0]), 32'd1);

    // Reset during D_STROBE
    push(0, 1'b1, 4'd9, 8'h77);
    step(6);
    chk("t5_in_dstrobe_bdir", 32'(bdir_v[0]), 32'd1);
    chk("t5_in_dstrobe_bc", 32'(bc_v[0]), 32'd0);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t5_rst_bdir", 32'(bdir_v[0]), 32'd0);
    chk("t5_rst_cs", 32'(cs_v[0]), 32'd0);
    chk("t5_rst_busy", 32'(busy_v[0]), 32'd0);
    step(2);
    RESET_N = 1'b1;
    step(1);
    s_a = astb[0]; s_d = dstb[0]; s_bl = badlen[0];
    push(0, 1'b1, 4'd9, 8'h33);
    wait_idle(0);
    chk("t5_addr_strobes", 32'(astb[0] - s_a), 32'd1);
    chk("t5_data_strobes", 32'(dstb[0] - s_d), 32'd1);
    chk("t5_psg_r9", 32'(psg_reg[0][9]), 32'h33);
    chk("t5_strobe_len", 32'(badlen[0] - s_bl), 32'd0);

    // SETUP_CYC=3, STROBE_CYC=1 instance
    s_a = astb[1]; s_d = dstb[1]; s_rv = rvcnt[1];
    s_bl = badlen[1]; s_bs = badsetup[1]; s_st = badstab[1];
    push(1, 1'b1, 4'd5, 8'hC3);
    step(4);
    chk("t6_astrobe_bdir", 32'(bdir_v[1]), 32'd1);
    chk("t6_astrobe_bc", 32'(bc_v[1]), 32'd1);
    chk("t6_astrobe_di", 32'(di_v[1]), 32'h05);
    step(1);
    chk("t6_arecov_bdir", 32'(bdir_v[1]), 32'd0);
    step(4);
    chk("t6_dstrobe_bdir", 32'(bdir_v[1]), 32'd1);
    chk("t6_dstrobe_bc", 32'(bc_v[1]), 32'd0);
    chk("t6_dstrobe_di", 32'(di_v[1]), 32'hC3);
    step(1);
    chk("t6_busy_c10", 32'(busy_v[1]), 32'd1);
    chk("t6_drecov_bdir", 32'(bdir_v[1]), 32'd0);
    step(1);
    chk("t6_busy_c11", 32'(busy_v[1]), 32'd0);
    push(1, 1'b0, 4'd5, 8'h00);
    push(1, 1'b1, 4'd6, 8'h5A);
    wait_idle(1);
    chk("t6_rdd", 32'(rdd_v[1]), 32'hC3);
    chk("t6_rdv_count", 32'(rvcnt[1] - s_rv), 32'd1);
    chk("t6_psg_r5", 32'(psg_reg[1][5]), 32'hC3);
    chk("t6_psg_r6", 32'(psg_reg[1][6]), 32'h5A);
    chk("t6_addr_strobes", 32'(astb[1] - s_a), 32'd2);
    chk("t6_data_strobes", 32'(dstb[1] - s_d), 32'd2);
    chk("t6_setup", 32'(badsetup[1] - s_bs), 32'd0);
    chk("t6_strobe_len", 32'(badlen[1] - s_bl), 32'd0);
    chk("t6_stable", 32'(badstab[1] - s_st), 32'd0);

    chk("all_setup_dut0", 32'(badsetup[0]), 32'd0);
    chk("all_stable_dut0", 32'(badstab[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
